// File: rtl/ps_window_accum.sv
// Windowed accumulator for the per-sample power stream: drops warm-up samples,
// sums fixed windows and presents each sum with a threshold flag on valid/ready.
module ps_window_accum #(
  parameter int unsigned data_width = 64,
  parameter int unsigned acc_width  = 80,
  parameter int unsigned win_len    = 256,
  parameter int unsigned warmup     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [data_width-1:0] din,
  input  logic                         din_valid,
  input  logic signed [acc_width-1:0]  threshold,
  output logic signed [acc_width-1:0]  dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         flag,
  output logic                         ovf
);

  localparam int unsigned CNT_W = (win_len > 2) ? $clog2(win_len) : 1;
  localparam int unsigned WU_W  = (warmup > 0) ? $clog2(warmup + 1) : 1;

  typedef enum logic {
    WARMUP = 1'b0,
    ACCUM  = 1'b1
  } state_e;

  state_e                       state_q;
  logic [WU_W-1:0]              wcnt_q;
  logic [CNT_W-1:0]             cnt_q;
  logic signed [acc_width-1:0]  acc_q;
  logic signed [acc_width-1:0]  dout_q;
  logic                         dout_valid_q;
  logic                         flag_q;
  logic                         ovf_q;

  logic                         accept_c;
  logic                         last_c;
  logic                         out_free_c;
  logic signed [acc_width-1:0]  din_ext_c;
  logic signed [acc_width-1:0]  acc_d;

  // Sample qualification and running sum including the current sample.
  always_comb begin
    accept_c   = din_valid && !en;
    din_ext_c  = acc_width'(din);
    acc_d      = acc_q + din_ext_c;
    last_c     = (state_q == ACCUM) && accept_c && (cnt_q == CNT_W'(win_len - 1));
    out_free_c = !dout_valid_q || dout_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= (warmup == 0) ? ACCUM : WARMUP;
      wcnt_q       <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      flag_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      // Consumption is honoured even while en holds the datapath.
      if (dout_valid_q && dout_ready) begin
        dout_valid_q <= 1'b0;
      end

      if (accept_c) begin
        case (state_q)
          WARMUP: begin
            wcnt_q <= wcnt_q + WU_W'(1);
            if (wcnt_q == WU_W'(warmup - 1)) begin
              state_q <= ACCUM;
            end
          end
          ACCUM: begin
            if (last_c) begin
              acc_q <= '0;
              cnt_q <= '0;
              // A completed window is either loaded or counted as dropped.
              if (out_free_c) begin
                dout_q       <= acc_d;
                flag_q       <= (acc_d > threshold);
                dout_valid_q <= 1'b1;
              end else begin
                ovf_q <= 1'b1;
              end
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= ACCUM;
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign flag       = flag_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_ps_window_accum.sv
// Self-checking bench for ps_window_accum: directed scenarios plus random
// traffic against a sample-queue reference model.
module tb_ps_window_accum;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 24;
  localparam int unsigned WIN = 4;
  localparam int unsigned WU  = 2;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic signed [DW-1:0]  din;
  logic                  din_valid;
  logic signed [AW-1:0]  threshold;
  logic signed [AW-1:0]  dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  flag;
  logic                  ovf;

  int checks;
  int errors;

  // Reference model state: expressed as sample lists, not counters.
  int      warm_seen;
  longint  win_q[$];
  longint  exp_dout;
  logic    exp_valid;
  logic    exp_flag;
  logic    exp_ovf;

  ps_window_accum #(
    .data_width(DW),
    .acc_width (AW),
    .win_len   (WIN),
    .warmup    (WU)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .din_valid (din_valid),
    .threshold (threshold),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .flag      (flag),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    longint sum;
    if (rst) begin
      warm_seen = 0;
      win_q.delete();
      exp_dout  = 0;
      exp_valid = 1'b0;
      exp_flag  = 1'b0;
      exp_ovf   = 1'b0;
    end else begin
      if (exp_valid && dout_ready) exp_valid = 1'b0;
      if (din_valid && !en) begin
        if (warm_seen < int'(WU)) begin
          warm_seen++;
        end else begin
          win_q.push_back(longint'(din));
          if (win_q.size() == int'(WIN)) begin
            sum = 0;
            foreach (win_q[i]) sum += win_q[i];
            win_q.delete();
            if (!exp_valid) begin
              exp_dout  = sum;
              exp_flag  = (sum > longint'(threshold));
              exp_valid = 1'b1;
            end else begin
              exp_ovf = 1'b1;
            end
          end
        end
      end
    end
  endtask

  // Drive one cycle, advance the model, then compare just after the edge.
  task automatic cyc(input logic r, input logic e, input logic dv,
                     input logic signed [DW-1:0] d, input logic rdy,
                     input logic signed [AW-1:0] th);
    rst        = r;
    en         = e;
    din_valid  = dv;
    din        = d;
    dout_ready = rdy;
    threshold  = th;
    model_step();
    @(posedge clk);
    #1;
    check("dout_valid", longint'(dout_valid), longint'(exp_valid));
    check("ovf", longint'(ovf), longint'(exp_ovf));
    if (exp_valid) begin
      check("dout", longint'(dout), exp_dout);
      check("flag", longint'(flag), longint'(exp_flag));
    end else begin
      check("dout_idle", longint'(dout), exp_dout);
    end
  endtask

  task automatic feed(input logic signed [DW-1:0] d, input logic rdy,
                      input logic signed [AW-1:0] th);
    cyc(1'b0, 1'b0, 1'b1, d, rdy, th);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; en = 1'b0; din = '0; din_valid = 1'b0;
    dout_ready = 1'b0; threshold = '0;
    warm_seen = 0; exp_dout = 0; exp_valid = 1'b0; exp_flag = 1'b0; exp_ovf = 1'b0;

    // Reset with live input
    cyc(1'b1, 1'b0, 1'b1, 16'sd7, 1'b1, 24'sd0);
    cyc(1'b1, 1'b0, 1'b1, 16'sd7, 1'b1, 24'sd0);
    check("rst_dout", longint'(dout), 0);
    check("rst_valid", longint'(dout_valid), 0);
    check("rst_flag_ovf", longint'({flag, ovf}), 0);

    // Warm-up then first window
    for (int i = 1; i <= 6; i++) feed(DW'(i), 1'b1, 24'sd17);
    check("basic_dout", longint'(dout), 18);
    check("basic_flag", longint'(flag), 1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 24'sd17);
    check("basic_one_cycle", longint'(dout_valid), 0);

    // en gating and idle gaps
    feed(16'sd10, 1'b1, 24'sd0);
    cyc(1'b0, 1'b1, 1'b1, 16'sd99, 1'b1, 24'sd0);
    feed(16'sd20, 1'b1, 24'sd0);
    cyc(1'b0, 1'b0, 1'b0, 16'sd99, 1'b1, 24'sd0);
    feed(16'sd30, 1'b1, 24'sd0);
    cyc(1'b0, 1'b1, 1'b1, 16'sd99, 1'b1, 24'sd0);
    cyc(1'b0, 1'b0, 1'b0, 16'sd0, 1'b1, 24'sd0);
    feed(16'sd40, 1'b1, 24'sd0);
    check("gate_dout", longint'(dout), 100);

    // Backpressure and overflow
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 24'sd0);
    for (int i = 0; i < 4; i++) feed(16'sd1, 1'b0, 24'sd0);
    for (int i = 0; i < 4; i++) feed(16'sd2, 1'b0, 24'sd0);
    check("bp_dout", longint'(dout), 4);
    check("bp_ovf", longint'(ovf), 1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 24'sd0);
    check("bp_drain", longint'(dout_valid), 0);
    check("bp_ovf_sticky", longint'(ovf), 1);

    // Negative window, then load on the consume cycle
    for (int i = 0; i < 4; i++) feed(-16'sd100, 1'b0, 24'sd0);
    check("neg_dout", longint'(dout), -400);
    check("neg_flag", longint'(flag), 0);
    for (int i = 0; i < 3; i++) feed(16'sd5, 1'b0, 24'sd0);
    feed(16'sd5, 1'b1, 24'sd0);
    check("simul_dout", longint'(dout), 20);
    check("simul_valid", longint'(dout_valid), 1);

    // Reset mid-window
    for (int i = 7; i <= 9; i++) feed(DW'(i), 1'b1, 24'sd17);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1, 24'sd17);
    for (int i = 1; i <= 6; i++) feed(DW'(i), 1'b1, 24'sd17);
    check("midrst_dout", longint'(dout), 18);
    check("midrst_ovf", longint'(ovf), 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
          DW'($urandom),
          ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0,
          ($urandom_range(0, 1) == 1) ? AW'($urandom) : AW'($signed($urandom_range(0, 40)) - 20));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps_window_accum.md
Name: ps_window_accum

Overview:
- Consumer end of the per-sample power stream produced by the power-stream compute unit (din[i-1]^2 - din[i-2]*din[i]).
- Discards the pipeline warm-up samples, then sums each fixed window of win_len samples. This sum is the un-normalised mean power; the 1/(N-2) division stays omitted by design.
- Each window sum is presented on a valid/ready output with a threshold-compare flag for downstream detection logic.

Parameters:
- data_width, 64, width of signed input power sample
- acc_width, 80, width of signed accumulator and result; must be >= data_width + clog2(win_len)
- win_len, 256, samples per window; must be >= 2
- warmup, 2, accepted samples discarded after reset

Ports:
- clk  input  1  clock, all logic on posedge
- rst  input  1  synchronous reset, active high
- en  input  1  enable, active low; when high, inputs are ignored and all state holds
- din  input  data_width  signed power sample
- din_valid  input  1  din carries a sample this cycle
- threshold  input  acc_width  signed compare level, sampled at window completion
- dout  output  acc_width  signed window sum
- dout_valid  output  1  dout/flag hold an unconsumed result
- dout_ready  input  1  consumer accepts result when dout_valid && dout_ready
- flag  output  1  1 when dout > threshold (strict, signed)
- ovf  output  1  sticky: a completed window was dropped because the output was still occupied

Behaviour:
- Reset (rst=1 at posedge): state=WARMUP, warm-up count=0, sample count=0, acc=0, dout=0, dout_valid=0, flag=0, ovf=0. rst has priority over everything.
- Sample accept: the sample is accepted at a posedge when din_valid=1 and en=0. With en=1, nothing changes except output consumption (dout_valid clears on dout_ready).
- WARMUP state:
  - Accepted samples are counted and discarded.
  - On the warmup-th accepted sample, go to ACCUM; acc stays 0.
  - If warmup=0, reset goes directly to ACCUM.
- ACCUM state:
  - acc <= acc + sign-extended din; sample count increments.
  - On the accepted sample with count = win_len-1:
    - result = acc + din.
    - acc <= 0, count <= 0; stay in ACCUM with no gap, so the next sample starts a new window.
- Result load:
  - If the output is free (dout_valid=0, or dout_valid && dout_ready in the same cycle): dout <= result, flag <= (result > threshold), dout_valid <= 1.
  - Otherwise: result dropped, dout/flag unchanged, ovf <= 1. ovf clears only on rst.
- Latency: dout_valid rises on the posedge of the last accepted sample, so it is visible the cycle after that sample is presented.
- Handshake:
  - dout/flag are stable while dout_valid=1 and dout_ready=0.
  - dout_valid clears on a posedge with dout_ready=1 and no simultaneous load.
  - A simultaneous consume and load leaves dout_valid=1 with the new value.
- Arithmetic: full-width signed two's-complement. No saturation, since parameter sizing guarantees no overflow.
- Reset mid-window: partial sum is lost and warm-up restarts. A pending unconsumed output is cleared.
- data_valid/din_valid gaps: count only advances on accepted samples. Windows span any number of idle cycles.

Test Plan:
- Bench parameters for all scenarios: data_width=16, acc_width=24, win_len=4, warmup=2.
- Reset check: assert rst 2 cycles with din_valid=1 and din=7 -> dout=0, dout_valid=0, flag=0, ovf=0 throughout.
- Warm-up and basic window: din=1,2,3,4,5,6 valid on consecutive cycles, threshold=17, dout_ready=1 -> 1 and 2 are dropped. Next cycle shows dout=18, flag=1, dout_valid=1 for exactly one cycle.
- en gating and idle gaps: window 10,20,30,40, with en=1 on two extra din_valid=1 cycles carrying 99 and two din_valid=0 cycles interleaved -> dout=100. The 99s are ignored.
- Backpressure and overflow: dout_ready=0, feed two full windows (1,1,1,1 then 2,2,2,2) -> dout stays 4, ovf=1. Then raise dout_ready -> dout_valid clears next cycle, ovf stays 1.
- Negative values and simultaneous consume/load: window -100 ×4 with threshold=0 -> dout=-400, flag=0. Hold dout_ready=1 while the next window (5 ×4) completes on the consume cycle -> dout=20, dout_valid stays 1.
- Reset mid-window: accept 3 window samples, pulse rst, then feed 1,2,3,4,5,6 -> first result is dout=18 (warm-up repeated, no residue).
